// File: rtl/bram_bist_ctrl.sv
// BIST sequencer for a simple-dual-port block RAM: writes an address-derived
// pattern, reads it back one word per cycle and reports mismatch statistics.
module bram_bist_ctrl #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 1,
   parameter int DEPTH  = 32768
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              check_only,
   input  logic              invert,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_din,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   // One extra counter bit so DEPTH == 2**ADDR_W still reaches its last value cleanly
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              inv_q, inv_d;
   logic [15:0]       err_q, err_d;
   logic [ADDR_W-1:0] ffa_q, ffa_d;
   logic              pass_q, pass_d;
   logic [ADDR_W-1:0] addr_p1_q;
   logic              vld_p1_q;
   logic              mismatch;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic inv);
      logic [DATA_W-1:0] p;
      for (int i = 0; i < DATA_W; i++) begin
         p[i] = a[i % ADDR_W];
      end
      return p ^ {DATA_W{inv}};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
         err_q   <= '0;
         ffa_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
         err_q   <= err_d;
         ffa_q   <= ffa_d;
         pass_q  <= pass_d;
      end
   end

   // Stage p1: read address delayed to line up with the memory's registered dout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_p1_q <= '0;
         vld_p1_q  <= 1'b0;
      end else begin
         addr_p1_q <= cnt_q[ADDR_W-1:0];
         vld_p1_q  <= (state_q == S_READ);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      inv_d     = inv_q;
      err_d     = err_q;
      ffa_d     = ffa_q;
      pass_d    = pass_q;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_din   = '0;
      mem_raddr = '0;

      mismatch = vld_p1_q && (mem_dout != pattern(addr_p1_q, inv_q));
      if (mismatch) begin
         err_d = sat_inc(err_q);
         if (err_q == 16'd0) begin
            ffa_d = addr_p1_q;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = check_only ? S_READ : S_WRITE;
               cnt_d   = '0;
               inv_d   = invert;
               err_d   = '0;
               ffa_d   = '0;
               pass_d  = 1'b0;
            end
         end
         S_WRITE: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_din   = pattern(cnt_q[ADDR_W-1:0], inv_q);
            if (cnt_q == LAST) begin
               state_d = S_READ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READ: begin
            mem_raddr = cnt_q[ADDR_W-1:0];
            if (cnt_q == LAST) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            pass_d  = (err_d == 16'd0);
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy            = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
   assign done            = (state_q == S_DONE);
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_bram_bist_ctrl.sv
// Bench for bram_bist_ctrl: memory model with fault mask, scoreboard of run
// results fed by a reference model, plus a large-depth saturation instance.
module tb_bram_bist_ctrl;
   localparam int AW  = 4;
   localparam int DW  = 1;
   localparam int DEP = 16;
   localparam int SAW = 17;
   localparam int SDEP = 70000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, check_only, invert;
   logic          busy, done, pass, we;
   logic [15:0]   err_count;
   logic [AW-1:0] ffa, waddr, raddr;
   logic [DW-1:0] din, dout;

   logic           s_start, s_check_only, s_invert, s_inv;
   logic           s_busy, s_done, s_pass, s_we;
   logic [15:0]    s_err;
   logic [SAW-1:0] s_ffa, s_waddr, s_raddr;
   logic [DW-1:0]  s_din, s_dout;

   bram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
      .clk(clk), .reset(reset), .start(start), .check_only(check_only), .invert(invert),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_fail_addr(ffa),
      .mem_waddr(waddr), .mem_we(we), .mem_din(din), .mem_raddr(raddr), .mem_dout(dout)
   );

   bram_bist_ctrl #(.ADDR_W(SAW), .DATA_W(DW), .DEPTH(SDEP)) dut_sat (
      .clk(clk), .reset(reset), .start(s_start), .check_only(s_check_only), .invert(s_invert),
      .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err), .first_fail_addr(s_ffa),
      .mem_waddr(s_waddr), .mem_we(s_we), .mem_din(s_din), .mem_raddr(s_raddr), .mem_dout(s_dout)
   );

   // Physical memory with a per-address read-inversion mask for fault injection
   logic [DEP-1:0] tbmem;
   logic [DEP-1:0] fault;
   always @(posedge clk) begin
      if (we) tbmem[waddr] <= din[0];
      dout <= tbmem[raddr] ^ fault[raddr];
   end

   // Saturation memory: every read returns the complement of the expected pattern
   always @(posedge clk) begin
      s_dout <= ~(s_raddr[0] ^ s_inv);
   end

   typedef struct {
      logic inv;
      logic pass;
      int   errs;
      int   ffa;
      int   busy_cyc;
      int   writes;
   } exp_t;

   exp_t sbq[$];
   int vectors = 0;
   int miscompares = 0;
   logic [DEP-1:0] ref_mem = '0;

   task automatic chk(input string name, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   function automatic logic pat(input int a, input logic inv);
      return logic'(a % 2) ^ inv;
   endfunction

   // Reference model: memory image after the run and the resulting compare outcome
   task automatic plan(input logic inv, input logic co, input logic [DEP-1:0] flt);
      exp_t e;
      int n = 0;
      int f = 0;
      if (!co) begin
         for (int a = 0; a < DEP; a++) ref_mem[a] = pat(a, inv);
      end
      for (int a = 0; a < DEP; a++) begin
         if ((ref_mem[a] ^ flt[a]) != pat(a, inv)) begin
            if (n == 0) f = a;
            n++;
         end
      end
      e.inv      = inv;
      e.pass     = (n == 0);
      e.errs     = n;
      e.ffa      = f;
      e.busy_cyc = co ? DEP + 1 : 2 * DEP + 1;
      e.writes   = co ? 0 : DEP;
      sbq.push_back(e);
   endtask

   // Monitor: checks every write and pops the scoreboard when done rises
   logic mon_bp = 1'b0;
   logic mon_dp = 1'b0;
   int   mon_bc = 0;
   int   mon_wc = 0;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (busy && !mon_bp) begin
            mon_bc = 0;
            mon_wc = 0;
         end
         if (busy) mon_bc++;
         if (we) begin
            if (sbq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               chk("write_addr", waddr, mon_wc);
               chk("write_data", din, pat(mon_wc, sbq[0].inv));
            end
            mon_wc++;
         end
         if (done && !mon_dp) begin
            if (sbq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               mon_e = sbq.pop_front();
               chk("pass", pass, mon_e.pass);
               chk("err_count", err_count, mon_e.errs);
               chk("first_fail_addr", ffa, mon_e.ffa);
               chk("busy_cycles", mon_bc, mon_e.busy_cyc);
               chk("write_count", mon_wc, mon_e.writes);
            end
         end
         mon_bp = busy;
         mon_dp = done;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_ffa"}, ffa, 0);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_raddr"}, raddr, 0);
      chk({tag, "_din"}, din, 0);
   endtask

   task automatic run(input logic inv, input logic co, input logic [DEP-1:0] flt, input bit pulse);
      int k;
      plan(inv, co, flt);
      @(negedge clk);
      fault = flt; invert = inv; check_only = co; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done_cleared", done, 0);
      chk("start_err_cleared", err_count, 0);
      chk("start_ffa_cleared", ffa, 0);
      for (k = 0; k < 200; k++) begin
         invert     = 1'($urandom);
         check_only = 1'($urandom);
         if (done) break;
         start = pulse && busy && ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      if (k == 200) chk("done_timeout", 0, 1);
   endtask

   initial begin
      exp_t ea;
      int k;
      int bc;
      int s_wr;
      reset = 1'b1; start = 1'b0; check_only = 1'b0; invert = 1'b0; fault = '0;
      s_start = 1'b0; s_check_only = 1'b0; s_invert = 1'b0; s_inv = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Clean, fault-injected, DRAIN-fault and check-only runs
      run(1'b0, 1'b0, 16'h0000, 1'b0);
      run(1'b0, 1'b0, 16'h0820, 1'b0);
      run(1'b0, 1'b0, 16'h8820, 1'b0);
      run(1'b1, 1'b1, 16'h0000, 1'b0);

      // Start pulses while busy are ignored; start in DONE clears and reruns
      run(1'($urandom), 1'b0, 16'h0421, 1'b1);
      repeat (3) @(negedge clk);
      chk("done_held", done, 1);
      chk("err_held", err_count, 3);
      run(1'($urandom), 1'b0, 16'($urandom) & 16'($urandom), 1'b1);

      // Asynchronous abort at write address 7
      ea.inv = 1'b0; ea.pass = 1'b0; ea.errs = 0; ea.ffa = 0; ea.busy_cyc = 0; ea.writes = 0;
      sbq.push_back(ea);
      @(negedge clk);
      fault = '0; invert = 1'b0; check_only = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (k = 0; k < 50; k++) begin
         if (we && waddr == 4'd7) break;
         @(negedge clk);
      end
      if (k == 50) chk("abort_timeout", 0, 1);
      #2 reset = 1'b1;
      #1 chk_zero("abort");
      sbq.delete(0);
      for (int a = 0; a < 7; a++) ref_mem[a] = pat(a, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_stays_idle", busy, 0);
      run(1'b0, 1'b0, 16'h0000, 1'b0);

      // Randomized runs against the reference model
      for (int r = 0; r < 6; r++) begin
         run(1'($urandom), 1'($urandom), 16'($urandom) & 16'($urandom), 1'($urandom));
      end

      // Saturation on a 70000-word instance with every read wrong
      @(negedge clk);
      s_invert = 1'($urandom); s_inv = s_invert; s_check_only = 1'b1; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      bc = 0; s_wr = 0;
      for (k = 0; k < SDEP + 1000; k++) begin
         s_invert = 1'($urandom);
         if (s_busy) bc++;
         if (s_we) begin
            s_wr++;
            $display("FAIL sat_write: data %0d at addr %0d, required no write", s_din, s_waddr);
         end
         if (s_done) break;
         @(negedge clk);
      end
      chk("sat_done", s_done, 1);
      chk("sat_busy_cycles", bc, SDEP + 1);
      chk("sat_writes", s_wr, 0);
      chk("sat_err_count", s_err, 16'hFFFF);
      chk("sat_pass", s_pass, 0);
      chk("sat_ffa", s_ffa, 0);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
